// File: rtl/mem_pkg.sv
// mem_pkg: shared size encodings, responder state type and lane helpers
package mem_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_t;
  function automatic logic [3:0] size_bytes(logic [1:0] s);
    return 4'd1 << s;
  endfunction
  // a shift by 64 for doubles yields zero, so the mask becomes all ones
  function automatic logic [63:0] size_mask(logic [1:0] s);
    return ~(64'hFFFF_FFFF_FFFF_FFFF << {size_bytes(s), 3'b000});
  endfunction
endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: byte-lane select/extend for loads, lane merge for stores
// Ports: word (64-bit memory word), offset (addr[2:0]), size, is_unsigned,
//        wdata (right-aligned store data) -> load_val, store_word, misaligned
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [63:0] word,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] wdata,
  output logic [63:0] load_val,
  output logic [63:0] store_word,
  output logic        misaligned
);
  logic [5:0]  sh;
  logic [63:0] lane;
  logic [63:0] mask;
  logic [3:0]  nb;
  always_comb begin
    sh         = {offset, 3'b000};
    lane       = word >> sh;
    mask       = size_mask(size) << sh;
    nb         = size_bytes(size);
    load_val   = size == SZ_B ? {{56{~is_unsigned & lane[7]}},  lane[7:0]}  :
                 size == SZ_H ? {{48{~is_unsigned & lane[15]}}, lane[15:0]} :
                 size == SZ_W ? {{32{~is_unsigned & lane[31]}}, lane[31:0]} : lane;
    store_word = (word & ~mask) | ((wdata << sh) & mask);
    misaligned = |({1'b0, offset} & (nb - 4'd1));
  end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated load/store responder over a 64-bit word array
// Ports: clk, rst_n (async active-low); req_valid/req_ready handshake with
//        req_write, req_addr, req_wdata, req_size, req_unsigned;
//        resp_valid/resp_ready handshake with resp_rdata, resp_err
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  if (LATENCY < 0 || LATENCY > 15) begin : g_lat_chk
    $error("data_mem_responder: LATENCY must be in 0..15");
  end
  mem_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [63:0] mem [DEPTH_WORDS];
  logic        accept, exec, err, mem_we;
  logic        f_write, f_uns, misaligned;
  logic [63:0] f_addr, f_wdata, word, load_val, store_word;
  logic [1:0]  f_size;
  mem_lane_unit u_lane (
    .word       (word),
    .offset     (f_addr[2:0]),
    .size       (f_size),
    .is_unsigned(f_uns),
    .wdata      (f_wdata),
    .load_val   (load_val),
    .store_word (store_word),
    .misaligned (misaligned)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end
  // Contents survive reset; a store is only written on its execute edge.
  always_ff @(posedge clk) begin
    if (mem_we) mem[f_addr[AW+2:3]] <= store_word;
  end
  always_comb begin
    accept      = req_valid & req_ready_q;
    // With zero latency the access executes on the acceptance edge itself,
    // so the lane unit works on the live request fields while idle.
    f_write     = state_q == IDLE ? req_write    : write_q;
    f_addr      = state_q == IDLE ? req_addr     : addr_q;
    f_wdata     = state_q == IDLE ? req_wdata    : wdata_q;
    f_size      = state_q == IDLE ? req_size     : size_q;
    f_uns       = state_q == IDLE ? req_unsigned : uns_q;
    word        = mem[f_addr[AW+2:3]];
    err         = misaligned | (f_addr[63:3] >= 61'(DEPTH_WORDS));
    exec        = (accept & (LATENCY == 0)) | (state_q == WAIT && cnt_q == 4'd0);
    mem_we      = exec & f_write & ~err;
    state_d     = accept ? (LATENCY == 0 ? RESP : WAIT) :
                  (state_q == WAIT && cnt_q == 4'd0) ? RESP :
                  (state_q == RESP && resp_ready) ? IDLE : state_q;
    cnt_d       = accept ? 4'(LATENCY - 1) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
    req_ready_d = state_d == IDLE;
    write_d     = accept ? req_write    : write_q;
    addr_d      = accept ? req_addr     : addr_q;
    wdata_d     = accept ? req_wdata    : wdata_q;
    size_d      = accept ? req_size     : size_q;
    uns_d       = accept ? req_unsigned : uns_q;
    rdata_d     = exec ? ((err | f_write) ? '0 : load_val) : rdata_q;
    err_d       = exec ? err : err_q;
  end
  always_comb begin
    req_ready  = req_ready_q;
    resp_valid = state_q == RESP;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks plus a byte-level reference model
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int LAT_A = 2;
  logic        clk = 1'b0;
  logic [2:0]  rstn = 3'b000;
  logic [2:0]  reqv = 3'b000;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_uns = 1'b0;
  logic        resp_ready = 1'b1;
  wire  [2:0]  rdy, vld, errw;
  wire  [63:0] rd [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_a (
    .clk(clk), .rst_n(rstn[0]), .req_valid(reqv[0]), .req_ready(rdy[0]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_uns), .resp_valid(vld[0]),
    .resp_ready(resp_ready), .resp_rdata(rd[0]), .resp_err(errw[0]));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_b (
    .clk(clk), .rst_n(rstn[1]), .req_valid(reqv[1]), .req_ready(rdy[1]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_uns), .resp_valid(vld[1]),
    .resp_ready(resp_ready), .resp_rdata(rd[1]), .resp_err(errw[1]));
  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_c (
    .clk(clk), .rst_n(rstn[2]), .req_valid(reqv[2]), .req_ready(rdy[2]),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_uns), .resp_valid(vld[2]),
    .resp_ready(resp_ready), .resp_rdata(rd[2]), .resp_err(errw[2]));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model of instance A: byte-addressed memory and a countdown
  // from acceptance to the response being offered.
  logic [7:0]  mem_m [8*DEPTH] = '{default: 8'h00};
  logic        m_ready = 1'b0;
  logic        m_pend = 1'b0;
  int          m_left = 0;
  logic [63:0] m_rdata = '0;
  logic        m_err = 1'b0;

  function automatic void model_access();
    int nb = 1 << req_size;
    logic [63:0] v = '0;
    m_err = (req_addr % 64'(nb) != 0) || (req_addr >= 64'(8 * DEPTH));
    m_rdata = '0;
    if (!m_err) begin
      for (int i = 0; i < nb; i++) begin
        if (req_write) mem_m[int'(req_addr) + i] = req_wdata[8*i +: 8];
        else v |= 64'(mem_m[int'(req_addr) + i]) << (8 * i);
      end
      if (!req_write && !req_uns && nb < 8 && v[8*nb-1]) v |= ~64'd0 << (8 * nb);
      if (!req_write) m_rdata = v;
    end
  endfunction

  always @(posedge clk or negedge rstn[0]) begin
    if (!rstn[0]) begin
      m_ready = 1'b0;
      m_pend  = 1'b0;
    end else if (!m_pend) begin
      if (reqv[0] && m_ready) begin
        model_access();
        m_pend  = 1'b1;
        m_left  = LAT_A;
        m_ready = 1'b0;
      end else m_ready = 1'b1;
    end else if (m_left > 0) m_left--;
    else if (resp_ready) begin
      m_pend  = 1'b0;
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("a_req_ready", 64'(rdy[0]), 64'(m_ready));
    chk("a_resp_valid", 64'(vld[0]), 64'(m_pend && m_left == 0));
    if (m_pend && m_left == 0) begin
      chk("a_resp_rdata", rd[0], m_rdata);
      chk("a_resp_err", 64'(errw[0]), 64'(m_err));
    end
  end

  task automatic xact(input int d, input logic w, input logic [63:0] a, input logic [63:0] wd,
                      input logic [1:0] sz, input logic u,
                      output logic [63:0] rdat, output logic e, output int lat);
    int n = 0;
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = wd; req_size = sz; req_uns = u;
    resp_ready = 1'b1;
    reqv[d] = 1'b1;
    while (!rdy[d] && n < 20) begin @(negedge clk); n++; end
    chk("accept_timeout", 64'(rdy[d]), 64'd1);
    @(posedge clk);
    @(negedge clk);
    reqv[d] = 1'b0;
    lat = 1;
    while (!vld[d] && lat < 40) begin @(negedge clk); lat++; end
    chk("resp_timeout", 64'(vld[d]), 64'd1);
    rdat = rd[d];
    e = errw[d];
    @(negedge clk);
  endtask

  task automatic do_chk(input string nm, input int d, input logic w, input logic [63:0] a,
                        input logic [63:0] wd, input logic [1:0] sz, input logic u,
                        input logic [63:0] er, input logic ee, input int el);
    logic [63:0] r;
    logic e;
    int lat;
    xact(d, w, a, wd, sz, u, r, e, lat);
    chk({nm, "_rdata"}, r, er);
    chk({nm, "_err"}, 64'(e), 64'(ee));
    chk({nm, "_lat"}, 64'(lat), 64'(el));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ready_low", 64'(rdy[0]), 64'd0);
    chk("rst_valid_low", 64'(vld[0]), 64'd0);
    rstn = 3'b111;
    @(negedge clk);
    chk("ready_after_release", 64'(rdy[0]), 64'd1);
    do_chk("st_d10", 0, 1, 64'h10, 64'h1122334455667788, 2'b11, 0, 64'h0, 0, 3);
    do_chk("ld_d10", 0, 0, 64'h10, 64'h0, 2'b11, 0, 64'h1122334455667788, 0, 3);
    do_chk("st_b13", 0, 1, 64'h13, 64'h123456789ABCDE80, 2'b00, 0, 64'h0, 0, 3);
    do_chk("ld_b13s", 0, 0, 64'h13, 64'h0, 2'b00, 0, 64'hFFFFFFFFFFFFFF80, 0, 3);
    do_chk("ld_b13u", 0, 0, 64'h13, 64'h0, 2'b00, 1, 64'h80, 0, 3);
    do_chk("ld_d10b", 0, 0, 64'h10, 64'h0, 2'b11, 0, 64'h1122334480667788, 0, 3);
    do_chk("ld_h12s", 0, 0, 64'h12, 64'h0, 2'b01, 0, 64'hFFFFFFFFFFFF8066, 0, 3);
    do_chk("ld_h16s", 0, 0, 64'h16, 64'h0, 2'b01, 0, 64'h1122, 0, 3);
    do_chk("ld_w14s", 0, 0, 64'h14, 64'h0, 2'b10, 0, 64'h11223344, 0, 3);
    do_chk("ld_w12_mis", 0, 0, 64'h12, 64'h0, 2'b10, 0, 64'h0, 1, 3);
    do_chk("st_d00", 0, 1, 64'h0, 64'hDEAD, 2'b11, 0, 64'h0, 0, 3);
    do_chk("st_d800_oor", 0, 1, 64'h800, 64'hFFFFFFFFFFFFFFFF, 2'b11, 0, 64'h0, 1, 3);
    do_chk("ld_d00", 0, 0, 64'h0, 64'h0, 2'b11, 0, 64'hDEAD, 0, 3);
    do_chk("st_h11_mis", 0, 1, 64'h11, 64'hBEEF, 2'b01, 0, 64'h0, 1, 3);
    do_chk("ld_d10c", 0, 0, 64'h10, 64'h0, 2'b11, 0, 64'h1122334480667788, 0, 3);
    do_chk("st_w18", 0, 1, 64'h18, 64'hCAFEBABE, 2'b10, 0, 64'h0, 0, 3);
    do_chk("ld_w18u", 0, 0, 64'h18, 64'h0, 2'b10, 1, 64'hCAFEBABE, 0, 3);
    do_chk("ld_w18s", 0, 0, 64'h18, 64'h0, 2'b10, 0, 64'hFFFFFFFFCAFEBABE, 0, 3);
    // Response stall with a second request waiting behind it.
    @(negedge clk);
    resp_ready = 1'b0;
    req_write = 1'b0; req_addr = 64'h10; req_size = 2'b11; req_uns = 1'b0;
    reqv[0] = 1'b1;
    n = 0;
    while (!rdy[0] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_addr = 64'h13; req_size = 2'b00; req_uns = 1'b1;
    n = 0;
    while (!vld[0] && n < 20) begin @(negedge clk); n++; end
    chk("stall_valid", 64'(vld[0]), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold_valid", 64'(vld[0]), 64'd1);
      chk("stall_hold_rdata", rd[0], 64'h1122334480667788);
      chk("stall_hold_ready", 64'(rdy[0]), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_ready", 64'(rdy[0]), 64'd1);
    chk("post_hs_valid", 64'(vld[0]), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reqv[0] = 1'b0;
    n = 0;
    while (!vld[0] && n < 20) begin @(negedge clk); n++; end
    chk("queued_ld_rdata", rd[0], 64'h80);
    @(negedge clk);
    // Zero-latency instance.
    do_chk("b_st", 1, 1, 64'h20, 64'hA5A5000012345678, 2'b11, 0, 64'h0, 0, 1);
    do_chk("b_ld", 1, 0, 64'h20, 64'h0, 2'b11, 0, 64'hA5A5000012345678, 0, 1);
    do_chk("b_ld_b27s", 1, 0, 64'h27, 64'h0, 2'b00, 0, 64'hFFFFFFFFFFFFFFA5, 0, 1);
    // Three-cycle instance: store aborted by reset while waiting.
    do_chk("c_st1", 2, 1, 64'h30, 64'h5555, 2'b11, 0, 64'h0, 0, 4);
    @(negedge clk);
    req_write = 1'b1; req_addr = 64'h30; req_wdata = 64'h6666; req_size = 2'b11;
    reqv[2] = 1'b1;
    n = 0;
    while (!rdy[2] && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    reqv[2] = 1'b0;
    rstn[2] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("c_rst_ready", 64'(rdy[2]), 64'd0);
      chk("c_rst_valid", 64'(vld[2]), 64'd0);
    end
    rstn[2] = 1'b1;
    @(negedge clk);
    chk("c_ready_after_rst", 64'(rdy[2]), 64'd1);
    do_chk("c_ld_after_abort", 2, 0, 64'h30, 64'h0, 2'b11, 0, 64'h5555, 0, 4);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
